// File: rtl/lcd_pkg.sv
// Shared opcodes, constants and state type for the LCD bus monitor slice.
package lcd_pkg;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_ENTRY     = 8'h04;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

  localparam logic [6:0] ROW1_BASE  = 7'h40;
  localparam logic [7:0] BLANK_CHAR = 8'h20;

  typedef enum logic {IDLE, CLEAR} mon_state_t;

endpackage

// File: rtl/lcd_shadow_ram.sv
// 32x8 shadow of display DDRAM: one synchronous write port, one registered read port.
module lcd_shadow_ram (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [7:0] wdata,
  input  logic [4:0] raddr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [32];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-cycle write/read to one address returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (reset) rd_data <= 8'h00;
    else       rd_data <= mem[raddr];
  end

endmodule

// File: rtl/lcd_bus_monitor.sv
// Decodes HD44780-style write strobes into a 2-row DDRAM shadow and flags protocol errors.
// Optional LCD_MON_STATS_EN adds saturating character/command counters.
module lcd_bus_monitor
  import lcd_pkg::*;
#(
  parameter int COLS        = 16,
  parameter int MIN_EN_HIGH = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] lcd_data,
  input  logic       lcd_rs,
  input  logic       lcd_en,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [4:0] cursor,
  output logic       busy,
  output logic       char_wr,
  output logic       err_timing,
  output logic       err_overrun,
  output logic       err_addr,
  input  logic       clr_err
`ifdef LCD_MON_STATS_EN
  ,
  output logic [15:0] wr_count,
  output logic [15:0] cmd_count
`endif
);

  localparam int         CW       = $clog2(MIN_EN_HIGH + 1);
  localparam logic [6:0] COLS7    = 7'(COLS);
  localparam logic [4:0] ROW1_ADR = 5'(COLS);

  mon_state_t state_q, state_d;

  logic          en_q, armed, rs_q, inc_mode;
  logic [7:0]    data_q;
  logic [CW-1:0] en_cnt;
  logic [4:0]    clr_cnt;

  logic       fall, short_pulse, accept, overrun;
  logic       is_char, is_cmd, cmd_clear, cmd_home, cmd_entry, cmd_ddram;
  logic [6:0] ddram_a, row1_off;
  logic       in_row0, in_row1;
  logic [4:0] ddram_target;

  logic       ram_we;
  logic [4:0] ram_waddr;
  logic [7:0] ram_wdata;

  // armed blocks a pulse that was already high when reset released.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q   <= 1'b0;
      armed  <= 1'b0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      en_cnt <= '0;
    end else begin
      en_q   <= lcd_en;
      rs_q   <= lcd_rs;
      data_q <= lcd_data;
      if (!lcd_en) armed <= 1'b1;
      if (!lcd_en)                          en_cnt <= '0;
      else if (en_cnt != CW'(MIN_EN_HIGH))  en_cnt <= en_cnt + 1'b1;
    end
  end

  assign fall        = en_q & ~lcd_en & armed;
  assign short_pulse = en_cnt < CW'(MIN_EN_HIGH);
  assign accept      = fall & (state_q == IDLE);
  assign overrun     = fall & (state_q == CLEAR);

  assign is_char   = accept & rs_q;
  assign is_cmd    = accept & ~rs_q;
  assign cmd_clear = is_cmd & (data_q == CMD_CLEAR);
  assign cmd_home  = is_cmd & (data_q[7:1] == CMD_HOME[7:1]);
  assign cmd_entry = is_cmd & (data_q[7:2] == CMD_ENTRY[7:2]);
  assign cmd_ddram = is_cmd & (data_q[7] == CMD_SET_DDRAM[7]);

  assign ddram_a      = data_q[6:0];
  assign row1_off     = ddram_a - ROW1_BASE;
  assign in_row0      = ddram_a < COLS7;
  assign in_row1      = (ddram_a >= ROW1_BASE) && (row1_off < COLS7);
  assign ddram_target = in_row0 ? ddram_a[4:0] : ROW1_ADR + row1_off[4:0];

  always_ff @(posedge clk) begin
    if (reset) state_q <= CLEAR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_clear)        state_d = CLEAR;
      CLEAR:   if (clr_cnt == 5'd31) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The sweep owns the RAM write port; character writes only happen in IDLE.
  always_comb begin
    busy      = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = cursor;
    ram_wdata = data_q;
    case (state_q)
      CLEAR: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = clr_cnt;
        ram_wdata = BLANK_CHAR;
      end
      default: ram_we = is_char;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt  <= 5'd0;
      cursor   <= 5'd0;
      inc_mode <= 1'b1;
      char_wr  <= 1'b0;
    end else begin
      clr_cnt <= (state_q == CLEAR) ? clr_cnt + 5'd1 : 5'd0;
      char_wr <= is_char;
      if (cmd_clear) begin
        cursor   <= 5'd0;
        inc_mode <= 1'b1;
      end else if (cmd_home) begin
        cursor <= 5'd0;
      end else if (cmd_entry) begin
        inc_mode <= data_q[1];
      end else if (cmd_ddram && (in_row0 || in_row1)) begin
        cursor <= ddram_target;
      end else if (is_char) begin
        cursor <= inc_mode ? cursor + 5'd1 : cursor - 5'd1;
      end
    end
  end

  // Sticky flags: a new set outranks clr_err in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_timing  <= 1'b0;
      err_overrun <= 1'b0;
      err_addr    <= 1'b0;
    end else begin
      if (fall && short_pulse)                        err_timing  <= 1'b1;
      else if (clr_err)                               err_timing  <= 1'b0;
      if (overrun)                                    err_overrun <= 1'b1;
      else if (clr_err)                               err_overrun <= 1'b0;
      if (cmd_ddram && !(in_row0 || in_row1))         err_addr    <= 1'b1;
      else if (clr_err)                               err_addr    <= 1'b0;
    end
  end

`ifdef LCD_MON_STATS_EN
  // Counts every completed strobe, including those discarded during a sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count  <= 16'h0000;
      cmd_count <= 16'h0000;
    end else begin
      if (fall && rs_q && (wr_count != 16'hFFFF))    wr_count  <= wr_count + 16'd1;
      if (fall && !rs_q && (cmd_count != 16'hFFFF))  cmd_count <= cmd_count + 16'd1;
    end
  end
`endif

  lcd_shadow_ram u_shadow (
    .clk     (clk),
    .reset   (reset),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr   (rd_addr),
    .rd_data (rd_char)
  );

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed self-checking bench for lcd_bus_monitor; stats checks follow LCD_MON_STATS_EN.
module tb_lcd_bus_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] lcd_data = 8'h00;
  logic       lcd_rs = 1'b0;
  logic       lcd_en = 1'b0;
  logic [4:0] rd_addr = 5'd0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_char;
  logic [4:0] cursor;
  logic       busy, char_wr, err_timing, err_overrun, err_addr;
`ifdef LCD_MON_STATS_EN
  logic [15:0] wr_count, cmd_count;
`endif

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;

  lcd_bus_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .lcd_data    (lcd_data),
    .lcd_rs      (lcd_rs),
    .lcd_en      (lcd_en),
    .rd_addr     (rd_addr),
    .rd_char     (rd_char),
    .cursor      (cursor),
    .busy        (busy),
    .char_wr     (char_wr),
    .err_timing  (err_timing),
    .err_overrun (err_overrun),
    .err_addr    (err_addr),
    .clr_err     (clr_err)
`ifdef LCD_MON_STATS_EN
    ,
    .wr_count    (wr_count),
    .cmd_count   (cmd_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (char_wr) wr_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One write strobe: en held high for hi cycles, then two settle cycles after the fall.
  task automatic applyStimulus(input logic rs, input logic [7:0] data, input int hi);
    @(posedge clk); #1;
    lcd_rs   = rs;
    lcd_data = data;
    lcd_en   = 1'b1;
    repeat (hi) @(posedge clk);
    #1 lcd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic readShadow(input logic [4:0] a, output logic [7:0] v);
    @(posedge clk); #1 rd_addr = a;
    @(posedge clk); #1 v = rd_char;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic doReset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic pulseClrErr();
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] walk [4];
    int n, base;
    walk[0] = 8'h57; walk[1] = 8'h41; walk[2] = 8'h4C; walk[3] = 8'h4B;

    doReset();
    checkOutput("rst_cursor", {27'd0, cursor}, 32'd0);
    checkOutput("rst_errs", {29'd0, err_timing, err_overrun, err_addr}, 32'd0);
    checkOutput("rst_char_wr", {31'd0, char_wr}, 32'd0);
    checkOutput("rst_rd_char", {24'd0, rd_char}, 32'd0);
    waitIdle(n);
    checkOutput("rst_busy_cycles", n, 32'd32);
    for (int a = 0; a < 32; a++) begin
      readShadow(5'(a), v);
      checkOutput($sformatf("blank_%0d", a), {24'd0, v}, 32'h20);
    end

    $display("[TB] write path");
    base = wr_pulses;
    applyStimulus(1'b0, 8'h80, 12);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, walk[i], 12);
    checkOutput("walk_cursor", {27'd0, cursor}, 32'd4);
    checkOutput("walk_pulses", wr_pulses - base, 32'd4);
    checkOutput("walk_timing", {31'd0, err_timing}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      readShadow(5'(i), v);
      checkOutput($sformatf("walk_%0d", i), {24'd0, v}, {24'd0, walk[i]});
    end

    $display("[TB] row addressing");
    applyStimulus(1'b0, 8'hC5, 12);
    applyStimulus(1'b1, 8'h41, 12);
    readShadow(5'd21, v);
    checkOutput("row1_char", {24'd0, v}, 32'h41);
    checkOutput("row1_cursor", {27'd0, cursor}, 32'd22);
    applyStimulus(1'b0, 8'h90, 12);
    checkOutput("bad_addr_flag", {31'd0, err_addr}, 32'd1);
    checkOutput("bad_addr_cursor", {27'd0, cursor}, 32'd22);
    pulseClrErr();
    checkOutput("clr_err_addr", {31'd0, err_addr}, 32'd0);

    $display("[TB] wrap and decrement");
    applyStimulus(1'b0, 8'hCF, 12);
    checkOutput("cursor_31", {27'd0, cursor}, 32'd31);
    applyStimulus(1'b1, 8'h58, 12);
    checkOutput("wrap_up", {27'd0, cursor}, 32'd0);
    readShadow(5'd31, v);
    checkOutput("char_31", {24'd0, v}, 32'h58);
    applyStimulus(1'b0, 8'h04, 12);
    applyStimulus(1'b1, 8'h59, 12);
    checkOutput("wrap_down", {27'd0, cursor}, 32'd31);
    readShadow(5'd0, v);
    checkOutput("char_0", {24'd0, v}, 32'h59);

    $display("[TB] timing and overrun");
    applyStimulus(1'b1, 8'h5A, 5);
    checkOutput("short_flag", {31'd0, err_timing}, 32'd1);
    checkOutput("short_cursor", {27'd0, cursor}, 32'd30);
    readShadow(5'd31, v);
    checkOutput("short_stored", {24'd0, v}, 32'h5A);
    pulseClrErr();
    checkOutput("clr_err_timing", {31'd0, err_timing}, 32'd0);
    applyStimulus(1'b0, 8'h01, 12);
    checkOutput("clear_busy", {31'd0, busy}, 32'd1);
    checkOutput("clear_cursor", {27'd0, cursor}, 32'd0);
    base = wr_pulses;
    applyStimulus(1'b1, 8'h42, 12);
    checkOutput("overrun_flag", {31'd0, err_overrun}, 32'd1);
    checkOutput("overrun_no_wr", wr_pulses - base, 32'd0);
    checkOutput("overrun_cursor", {27'd0, cursor}, 32'd0);
    checkOutput("overrun_timing", {31'd0, err_timing}, 32'd0);
    waitIdle(n);
    readShadow(5'd21, v);
    checkOutput("cleared_21", {24'd0, v}, 32'h20);
    applyStimulus(1'b1, 8'h43, 12);
    checkOutput("clear_inc_mode", {27'd0, cursor}, 32'd1);
    readShadow(5'd0, v);
    checkOutput("after_clear_0", {24'd0, v}, 32'h43);

    $display("[TB] stats");
    doReset();
    checkOutput("rst2_overrun", {31'd0, err_overrun}, 32'd0);
    waitIdle(n);
    checkOutput("rst2_busy_cycles", n, 32'd32);
    applyStimulus(1'b0, 8'h80, 12);
    applyStimulus(1'b0, 8'h06, 12);
    applyStimulus(1'b1, 8'h31, 12);
    applyStimulus(1'b1, 8'h32, 12);
    applyStimulus(1'b1, 8'h33, 12);
    checkOutput("stats_cursor", {27'd0, cursor}, 32'd3);
`ifdef LCD_MON_STATS_EN
    checkOutput("wr_count", {16'd0, wr_count}, 32'd3);
    checkOutput("cmd_count", {16'd0, cmd_count}, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
